// File: rtl/load_group_arbiter_pkg.sv
// Shared state encoding, counter widths and index-width helper for load_group_arbiter.
package load_group_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int GRANT_CNT_W = 16;
    localparam int BEAT_CNT_W  = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/load_group_arbiter_rr_pick.sv
// Rotating priority pick: first set bit of req searching ptr, ptr+1, ... with wrap.
module rr_pick
    import load_group_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    int cand;

    // Walk the search order backwards so the last hit is the closest to ptr.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/load_group_arbiter.sv
// Round-robin arbiter sharing one registered output beat among NUM_REQ load groups.
// Optional grant counter enabled by LOAD_GROUP_ARBITER_STATS_EN.
module load_group_arbiter
    import load_group_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_owner,
    input  logic                       out_ready,
    output logic                       busy
`ifdef LOAD_GROUP_ARBITER_STATS_EN
    ,
    input  logic                       stats_clr,
    output logic [GRANT_CNT_W-1:0]     grant_count
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  out_valid_d;
    logic [DATA_W-1:0]     out_data_d;
    logic [IDX_W-1:0]      out_owner_d;

    logic                  pick_any;
    logic [IDX_W-1:0]      pick_idx;
    logic                  load_en;
    logic                  accept;
    logic                  release_grant;
    logic [DATA_W-1:0]     data_arr [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign load_en = !out_valid || out_ready;
    assign accept  = (|(gnt & req)) && load_en;
    assign busy    = (state_q != IDLE) || out_valid;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt;
        owner_d       = owner_q;
        beat_cnt_d    = beat_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        out_valid_d   = out_valid;
        out_data_d    = out_data;
        out_owner_d   = out_owner;
        release_grant = 1'b0;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = data_arr[owner_q];
            out_owner_d = owner_q;
            beat_cnt_d  = beat_cnt_q + BEAT_CNT_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    beat_cnt_d      = '0;
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                // A stalled beat neither counts nor releases while the owner keeps requesting.
                if (accept) begin
                    release_grant = req_last[owner_q] ||
                                    (beat_cnt_q == BEAT_CNT_W'(MAX_HOLD - 1));
                end else begin
                    release_grant = !req[owner_q];
                end
                if (release_grant) begin
                    gnt_d    = '0;
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt        <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_owner  <= '0;
        end else begin
            state_q    <= state_d;
            gnt        <= gnt_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            out_owner  <= out_owner_d;
        end
    end

`ifdef LOAD_GROUP_ARBITER_STATS_EN
    logic grant_start;

    assign grant_start = (state_q == IDLE) && pick_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_count <= '0;
        end else if (stats_clr) begin
            grant_count <= '0;
        end else if (grant_start && (grant_count != '1)) begin
            grant_count <= grant_count + GRANT_CNT_W'(1);
        end
    end
`endif

endmodule
